pc_stack_ctrl: RTL and testbench
================================

PC_STACK_CTRL -- requirements
Module: pc_stack_ctrl

Interface
REQ-001 Parameter AW, default 4, address/data width of the program counter and of the stack data path.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 advance  input  1  sequential step: pc <= pc+1 when idle.
REQ-005 call  input  1  subroutine call request, sampled in IDLE only.
REQ-006 ret  input  1  subroutine return request, sampled in IDLE only.
REQ-007 tgt  input  AW  call target address, sampled with call.
REQ-008 stk_full  input  1  stack cannot accept a push.
REQ-009 stk_empty  input  1  stack holds no entry.
REQ-010 stk_dout  input  AW  stack read data, valid the cycle after a pop cycle.
REQ-011 stk_en  output  1  stack enable, one-cycle strobe per operation.
REQ-012 stk_rw  output  1  stack direction: 0 = push, 1 = pop.
REQ-013 stk_din  output  AW  stack write data (the return address).
REQ-014 pc  output  AW  current program counter.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err_ovf  output  1  sticky: call rejected because stk_full.
REQ-017 err_unf  output  1  sticky: ret rejected because stk_empty.

Function
REQ-018 FSM states SHALL be IDLE, PUSH, POP and LOAD; busy = (state != IDLE).
REQ-019 In IDLE, requests SHALL take this priority: call > ret > advance. Lower-priority requests in the same cycle are dropped, not queued.
REQ-020 IDLE with call=1 and stk_full=0: the block SHALL capture ra = pc+1 (mod 2^AW) and tgt, and go to PUSH.
REQ-021 PUSH (one cycle): stk_en=1, stk_rw=0, stk_din=ra; at the cycle end pc <= captured tgt and the FSM returns to IDLE. Call-to-new-pc latency is 2 edges.
REQ-022 IDLE with call=1 and stk_full=1: no stack access, pc unchanged, err_ovf <= 1, stay in IDLE.
REQ-023 IDLE with ret=1 (call=0) and stk_empty=0: the FSM SHALL go to POP.
REQ-024 POP (one cycle): stk_en=1, stk_rw=1, then go to LOAD.
REQ-025 LOAD (one cycle): stk_en=0, pc <= stk_dout, then go to IDLE. Ret-to-new-pc latency is 3 edges.
REQ-026 IDLE with ret=1 (call=0) and stk_empty=1: no stack access, pc unchanged, err_unf <= 1, stay in IDLE.
REQ-027 IDLE with advance=1 only: pc <= pc+1 with wrap from 2^AW-1 to 0. stk_en stays 0.
REQ-028 While busy, call, ret, advance and tgt SHALL be ignored.
REQ-029 stk_en SHALL be high only in PUSH and POP, exactly one cycle per accepted operation. stk_rw and stk_din hold their last values otherwise.
REQ-030 err_ovf and err_unf SHALL stay set until reset.
REQ-031 stk_full and stk_empty SHALL be sampled only in IDLE when a request is evaluated.

Reset
REQ-032 rst low SHALL immediately force: state=IDLE, pc=0, stk_en=0, stk_rw=0, stk_din=0, busy=0, err_ovf=0, err_unf=0.
REQ-033 Reset asserted during PUSH, POP or LOAD SHALL abort the operation with no further stack strobe and no pc load. Stack contents are not the block's responsibility.
REQ-034 After rst deasserts, the first rising edge SHALL evaluate requests normally from IDLE.

Verification
REQ-035 Reset then advance high for 17 cycles -> pc counts 1..F, wraps to 0, then 1. stk_en never high.
REQ-036 pc=3, call with tgt=4'hA, stk_full=0 -> next cycle stk_en=1, stk_rw=0, stk_din=4, busy=1; following edge pc=A, busy=0.
REQ-037 pc=A, ret with stk_empty=0 -> POP cycle with stk_en=1, stk_rw=1; stk_dout=4 presented in LOAD -> pc=4, busy=0, 3 edges after request.
REQ-038 call with stk_full=1 -> err_ovf=1, pc unchanged, no strobe; ret with stk_empty=1 -> err_unf=1. Both flags persist until rst.
REQ-039 call, ret and advance high together at pc=5, tgt=2 -> only the push of 6 occurs and pc=2. Requests raised while busy are ignored.
REQ-040 rst pulsed low mid-POP -> outputs reset immediately, no LOAD occurs, pc=0 afterwards.

Source files
------------

// File: rtl/pc_stack_ctrl.sv
// rtl/pc_stack_ctrl.sv - program counter sequencer with call/return through an external stack
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   advance, call, ret  step / subroutine call / subroutine return requests (IDLE only)
//   tgt                 call target address, sampled with call
//   stk_full, stk_empty external stack status, sampled in IDLE with a request
//   stk_dout            stack read data, valid the cycle after the pop strobe
//   stk_en, stk_rw      one-cycle stack strobe; rw 0 = push, 1 = pop
//   stk_din             stack write data (return address)
//   pc                  current program counter
//   busy                high outside IDLE
//   err_ovf, err_unf    sticky rejected-call / rejected-return flags

module pc_stack_ctrl #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] tgt,
    input  logic          stk_full,
    input  logic          stk_empty,
    input  logic [AW-1:0] stk_dout,
    output logic          stk_en,
    output logic          stk_rw,
    output logic [AW-1:0] stk_din,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          err_ovf,
    output logic          err_unf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        LOAD = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] tgt_q;
    logic          do_call;
    logic          do_ret;
    logic          do_adv;
    logic          rej_call;
    logic          rej_ret;

    // Request arbitration happens only in IDLE; call beats ret beats advance,
    // and losing requests are simply dropped.
    always_comb begin
        state_nxt = state;
        do_call   = 1'b0;
        do_ret    = 1'b0;
        do_adv    = 1'b0;
        rej_call  = 1'b0;
        rej_ret   = 1'b0;
        case (state)
            IDLE: begin
                if (call) begin
                    if (stk_full) begin
                        rej_call = 1'b1;
                    end else begin
                        do_call   = 1'b1;
                        state_nxt = PUSH;
                    end
                end else if (ret) begin
                    if (stk_empty) begin
                        rej_ret = 1'b1;
                    end else begin
                        do_ret    = 1'b1;
                        state_nxt = POP;
                    end
                end else if (advance) begin
                    do_adv = 1'b1;
                end
            end
            PUSH:    state_nxt = IDLE;
            POP:     state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The stack strobe is registered on acceptance so it is high for exactly
    // the PUSH or POP cycle; stk_din doubles as the captured return address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            tgt_q   <= '0;
            stk_en  <= 1'b0;
            stk_rw  <= 1'b0;
            stk_din <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            stk_en <= do_call | do_ret;
            if (do_call) begin
                stk_rw  <= 1'b0;
                stk_din <= pc + AW'(1);
                tgt_q   <= tgt;
            end
            if (do_ret) begin
                stk_rw <= 1'b1;
            end
            if (do_adv) begin
                pc <= pc + AW'(1);
            end else if (state == PUSH) begin
                pc <= tgt_q;
            end else if (state == LOAD) begin
                pc <= stk_dout;
            end
            if (rej_call) begin
                err_ovf <= 1'b1;
            end
            if (rej_ret) begin
                err_unf <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb/tb_pc_stack_ctrl.sv - scoreboard bench for pc_stack_ctrl with random and directed requests

module tb_pc_stack_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          advance;
    logic          call;
    logic          ret;
    logic [AW-1:0] tgt;
    logic          stk_full;
    logic          stk_empty;
    logic [AW-1:0] stk_dout;
    logic          stk_en;
    logic          stk_rw;
    logic [AW-1:0] stk_din;
    logic [AW-1:0] pc;
    logic          busy;
    logic          err_ovf;
    logic          err_unf;

    always #5 clk = ~clk;

    pc_stack_ctrl #(.AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .call      (call),
        .ret       (ret),
        .tgt       (tgt),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_dout  (stk_dout),
        .stk_en    (stk_en),
        .stk_rw    (stk_rw),
        .stk_din   (stk_din),
        .pc        (pc),
        .busy      (busy),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    // External stack device
    logic [AW-1:0] mem [DEPTH];
    int            sp;
    logic [AW-1:0] dout;

    assign stk_full  = (sp == DEPTH);
    assign stk_empty = (sp == 0);
    assign stk_dout  = dout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp   <= 0;
            dout <= '0;
        end else if (stk_en) begin
            if (!stk_rw) begin
                if (sp < DEPTH) begin
                    mem[sp] <= stk_din;
                    sp      <= sp + 1;
                end
            end else if (sp > 0) begin
                dout <= mem[sp-1];
                sp   <= sp - 1;
            end
        end
    end

    // Reference model and scoreboard queues
    typedef struct {
        logic [AW-1:0] pc;
        logic          ovf;
        logic          unf;
        int            nbusy;
    } exp_t;

    typedef struct {
        logic          rw;
        logic [AW-1:0] din;
    } op_t;

    exp_t          expq[$];
    op_t           opq[$];
    logic [AW-1:0] m_pc;
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] m_stk[$];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        m_pc  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_stk.delete();
        expq.delete();
        opq.delete();
        e.pc    = '0;
        e.ovf   = 1'b0;
        e.unf   = 1'b0;
        e.nbusy = 0;
        expq.push_back(e);
    endtask

    // Wait for an idle cycle (scribbling junk on the inputs while busy),
    // present one request and record what the model says must follow.
    task automatic do_req(input logic c, input logic r, input logic a, input logic [AW-1:0] t);
        int   n;
        int   nb;
        exp_t e;
        op_t  o;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            call    = 1'($urandom);
            ret     = 1'($urandom);
            advance = 1'($urandom);
            tgt     = AW'($urandom);
            n++;
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
        call    = c;
        ret     = r;
        advance = a;
        tgt     = t;
        nb      = 0;
        if (c) begin
            if (m_stk.size() == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                o.rw  = 1'b0;
                o.din = m_pc + AW'(1);
                opq.push_back(o);
                m_stk.push_back(m_pc + AW'(1));
                m_pc = t;
                nb   = 1;
            end
        end else if (r) begin
            if (m_stk.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                o.rw  = 1'b1;
                o.din = '0;
                opq.push_back(o);
                m_pc = m_stk.pop_back();
                nb   = 2;
            end
        end else if (a) begin
            m_pc = m_pc + AW'(1);
        end
        e.pc    = m_pc;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.nbusy = nb;
        expq.push_back(e);
    endtask

    // Monitor: strobes are matched against expected stack ops; every idle
    // cycle is matched against the state the previous request should leave.
    int   bcnt = 0;
    exp_t me;
    op_t  mo;

    always @(negedge clk) begin
        if (!rst) begin
            bcnt = 0;
        end else begin
            if (stk_en) begin
                if (opq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe: got unexpected stk_en=1 (rw=%0d din=%0h) expected none", stk_rw, stk_din);
                end else begin
                    mo = opq.pop_front();
                    chk("strobe_rw", int'(stk_rw), int'(mo.rw));
                    if (!mo.rw) chk("strobe_din", int'(stk_din), int'(mo.din));
                end
            end
            if (busy) begin
                bcnt++;
            end else begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL idle_state: got idle cycle with pc=%0h expected no pending result", pc);
                end else begin
                    me = expq.pop_front();
                    chk("pc", int'(pc), int'(me.pc));
                    chk("err_ovf", int'(err_ovf), int'(me.ovf));
                    chk("err_unf", int'(err_unf), int'(me.unf));
                    chk("busy_cycles", bcnt, me.nbusy);
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        advance = 1'b0;
        tgt     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Counting with wrap: 1..F, 0, 1, then on to 3
        repeat (17) do_req(1'b0, 1'b0, 1'b1, '0);
        repeat (2) do_req(1'b0, 1'b0, 1'b1, '0);

        // Call from 3 to A, then return to 4
        do_req(1'b1, 1'b0, 1'b0, 4'hA);
        do_req(1'b0, 1'b1, 1'b0, '0);

        // Fill the stack, overflow, drain, underflow
        repeat (DEPTH) do_req(1'b1, 1'b0, 1'b0, AW'($urandom));
        do_req(1'b1, 1'b0, 1'b0, 4'h7);
        repeat (DEPTH) do_req(1'b0, 1'b1, 1'b0, '0);
        do_req(1'b0, 1'b1, 1'b0, '0);

        // Simultaneous requests at pc=5
        for (int i = 0; i < 16 && m_pc != 4'h5; i++) do_req(1'b0, 1'b0, 1'b1, '0);
        do_req(1'b1, 1'b1, 1'b1, 4'h2);

        // Random traffic
        repeat (300) begin
            do_req($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1, AW'($urandom));
        end

        // Reset in the middle of a POP
        if (m_stk.size() == 0) do_req(1'b1, 1'b0, 1'b0, 4'h9);
        do_req(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        call    = 1'b0;
        ret     = 1'b0;
        advance = 1'b0;
        #1;
        chk("rst_stk_en", int'(stk_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_stk_rw", int'(stk_rw), 0);
        chk("rst_stk_din", int'(stk_din), 0);
        chk("rst_err_ovf", int'(err_ovf), 0);
        chk("rst_err_unf", int'(err_unf), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_pc", int'(pc), 0);
        chk("rst_hold_stk_en", int'(stk_en), 0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Normal operation right after reset
        do_req(1'b0, 1'b0, 1'b1, '0);
        do_req(1'b1, 1'b0, 1'b0, 4'hC);
        do_req(1'b0, 1'b1, 1'b0, '0);
        do_req(1'b0, 1'b1, 1'b0, '0);
        do_req(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        chk("exp_left", expq.size(), 0);
        chk("ops_left", opq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
